// File: rtl/mbfft_ctrl_p.sv
// Sequencer for a memory-based radix-2 DIF FFT on two dual-port banks:
// frame load, LOG2N in-place butterfly stages and bit-reversed unload.
module mbfft_ctrl_p #(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    input  logic             inv,
    output logic             tw_conj,
    output logic             sel_din,
    output logic             wr_en_b0,
    output logic             wr_en_b1,
    output logic [LOG2N-2:0] wr_addr_b0,
    output logic [LOG2N-2:0] wr_addr_b1,
    output logic             wr_swap,
    output logic [LOG2N-2:0] rd_addr_b0,
    output logic [LOG2N-2:0] rd_addr_b1,
    output logic             rd_swap,
    output logic             bf_vld,
    output logic [LOG2N-2:0] tw_addr,
    output logic [3:0]       stage,
    output logic             busy
);

    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N - 1;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] J_LAST = LOG2N'(N / 2 - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);
    localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN, ST_UNLOAD} state_t;

    function automatic logic bank_of(input logic [LOG2N-1:0] i);
        return ^i;
    endfunction

    function automatic logic [AW-1:0] row_of(input logic [LOG2N-1:0] i);
        return i[LOG2N-1:1];
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [3:0]       stage_q, stage_d;
    logic             inv_q, inv_d;
    logic             out_vld_q, out_vld_d;
    logic [BF_LAT-1:0] sr_vld_q, sr_vld_d;
    logic [BF_LAT-1:0] sr_swap_q, sr_swap_d;
    logic [AW-1:0]     sr_a0_q [BF_LAT];
    logic [AW-1:0]     sr_a0_d [BF_LAT];
    logic [AW-1:0]     sr_a1_q [BF_LAT];
    logic [AW-1:0]     sr_a1_d [BF_LAT];

    logic             acc, xfer;
    logic [3:0]       b;
    logic [LOG2N-1:0] lo_mask, p, q, tw_full, ka, ri;

    assign tw_conj = inv_q;
    assign stage   = stage_q;
    assign out_vld = out_vld_q;
    assign busy    = (state_q != ST_LOAD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        stage_d    = stage_q;
        inv_d      = inv_q;
        out_vld_d  = out_vld_q;
        in_rdy     = 1'b0;
        sel_din    = 1'b0;
        wr_en_b0   = 1'b0;
        wr_en_b1   = 1'b0;
        wr_addr_b0 = '0;
        wr_addr_b1 = '0;
        wr_swap    = 1'b0;
        rd_addr_b0 = '0;
        rd_addr_b1 = '0;
        rd_swap    = 1'b0;
        bf_vld     = 1'b0;
        tw_addr    = '0;
        acc        = 1'b0;
        xfer       = 1'b0;
        b          = 4'(LOG2N - 1) - stage_q;
        lo_mask    = (LOG2N'(1) << b) - LOG2N'(1);
        p          = ((cnt_q & ~lo_mask) << 1) | (cnt_q & lo_mask);
        q          = p | (LOG2N'(1) << b);
        tw_full    = (p & lo_mask) << stage_q;
        ka         = '0;
        ri         = '0;

        case (state_q)
            ST_LOAD: begin
                in_rdy = 1'b1;
                acc    = in_vld & ~rst;
                if (acc) begin
                    sel_din    = 1'b1;
                    wr_en_b0   = ~bank_of(cnt_q);
                    wr_en_b1   = bank_of(cnt_q);
                    wr_addr_b0 = row_of(cnt_q);
                    wr_addr_b1 = row_of(cnt_q);
                    wr_swap    = bank_of(cnt_q);
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == K_LAST) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                        inv_d   = inv;
                    end
                end
            end
            ST_COMPUTE: begin
                bf_vld  = 1'b1;
                rd_swap = bank_of(p);
                if (bank_of(p)) begin
                    rd_addr_b0 = row_of(q);
                    rd_addr_b1 = row_of(p);
                end else begin
                    rd_addr_b0 = row_of(p);
                    rd_addr_b1 = row_of(q);
                end
                tw_addr = tw_full[AW-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == J_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                // Hold off the next stage until the last write-back has issued.
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == D_LAST) begin
                    dcnt_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = ST_UNLOAD;
                        stage_d = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COMPUTE;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            ST_UNLOAD: begin
                // Look ahead by the transfer so the bank output is valid next cycle.
                xfer       = out_vld_q & out_rdy;
                ka         = cnt_q + LOG2N'(xfer);
                ri         = bitrev(ka);
                rd_swap    = bank_of(ri);
                rd_addr_b0 = row_of(ri);
                rd_addr_b1 = row_of(ri);
                out_vld_d  = 1'b1;
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == K_LAST) begin
                        state_d   = ST_LOAD;
                        cnt_d     = '0;
                        out_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (sr_vld_q[BF_LAT-1]) begin
            sel_din    = 1'b0;
            wr_en_b0   = 1'b1;
            wr_en_b1   = 1'b1;
            wr_addr_b0 = sr_a0_q[BF_LAT-1];
            wr_addr_b1 = sr_a1_q[BF_LAT-1];
            wr_swap    = sr_swap_q[BF_LAT-1];
        end

        sr_vld_d[0]  = bf_vld;
        sr_swap_d[0] = rd_swap;
        sr_a0_d[0]   = rd_addr_b0;
        sr_a1_d[0]   = rd_addr_b1;
        for (int i = 1; i < BF_LAT; i++) begin
            sr_vld_d[i]  = sr_vld_q[i-1];
            sr_swap_d[i] = sr_swap_q[i-1];
            sr_a0_d[i]   = sr_a0_q[i-1];
            sr_a1_d[i]   = sr_a1_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            stage_q   <= '0;
            inv_q     <= 1'b0;
            out_vld_q <= 1'b0;
            sr_vld_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            stage_q   <= stage_d;
            inv_q     <= inv_d;
            out_vld_q <= out_vld_d;
            sr_vld_q  <= sr_vld_d;
        end
    end

    // Write-back payload; only meaningful alongside its valid bit.
    always_ff @(posedge clk) begin
        sr_swap_q <= sr_swap_d;
        for (int i = 0; i < BF_LAT; i++) begin
            sr_a0_q[i] <= sr_a0_d[i];
            sr_a1_q[i] <= sr_a1_d[i];
        end
    end

endmodule

// File: tb/tb_mbfft_ctrl_p.sv
// Randomized bench for mbfft_ctrl_p: per-cycle comparison against a schedule
// built directly from the FFT index arithmetic.
module tb_mbfft_ctrl_p;
    localparam int L   = 4;
    localparam int LAT = 3;
    localparam int N   = 1 << L;
    localparam int H   = N / 2;
    localparam int TOT = L * (H + LAT);
    localparam int MAXC = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_vld = 1'b0, out_rdy = 1'b0, inv = 1'b0;
    logic in_rdy, out_vld, tw_conj, sel_din, wr_en_b0, wr_en_b1, wr_swap, rd_swap, bf_vld, busy;
    logic [L-2:0] wr_addr_b0, wr_addr_b1, rd_addr_b0, rd_addr_b1, tw_addr;
    logic [3:0] stage;

    mbfft_ctrl_p #(.LOG2N(L), .BF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .inv(inv), .tw_conj(tw_conj),
        .sel_din(sel_din), .wr_en_b0(wr_en_b0), .wr_en_b1(wr_en_b1),
        .wr_addr_b0(wr_addr_b0), .wr_addr_b1(wr_addr_b1), .wr_swap(wr_swap),
        .rd_addr_b0(rd_addr_b0), .rd_addr_b1(rd_addr_b1), .rd_swap(rd_swap),
        .bf_vld(bf_vld), .tw_addr(tw_addr), .stage(stage), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected compute-phase schedule, indexed by cycle since first bf_vld.
    int t_bf[TOT], t_rd0[TOT], t_rd1[TOT], t_rsw[TOT], t_tw[TOT], t_stg[TOT];
    int t_wen[TOT], t_wa0[TOT], t_wa1[TOT], t_wsw[TOT];

    function automatic int par(input int x);
        return $countones(x) % 2;
    endfunction

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < L; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    task automatic build_tables();
        for (int c = 0; c < TOT; c++) begin
            t_bf[c] = 0; t_wen[c] = 0; t_stg[c] = c / (H + LAT);
        end
        for (int s = 0; s < L; s++) begin
            int b = L - 1 - s;
            for (int j = 0; j < H; j++) begin
                int c = s * (H + LAT) + j;
                int p = (j / (1 << b)) * (1 << (b + 1)) + j % (1 << b);
                int q = p + (1 << b);
                t_bf[c]  = 1;
                t_rsw[c] = par(p);
                t_rd0[c] = (par(p) == 0) ? p / 2 : q / 2;
                t_rd1[c] = (par(p) == 0) ? q / 2 : p / 2;
                t_tw[c]  = ((p % (1 << b)) * (1 << s)) % H;
                t_wen[c + LAT] = 1;
                t_wa0[c + LAT] = t_rd0[c];
                t_wa1[c + LAT] = t_rd1[c];
                t_wsw[c + LAT] = t_rsw[c];
            end
        end
    endtask

    // Model state: phase 0 = loading, 1 = computing, 2 = unloading.
    int ph = 0, k = 0, c = 0, ov = 0, exp_conj = 0, frames_done = 0;
    bit rst_done = 0;

    task automatic check_and_update();
        chk("tw_conj", tw_conj, exp_conj);
        if (ph == 0) begin
            int acc = in_vld;
            chk("ld_in_rdy", in_rdy, 1);
            chk("ld_busy", busy, 0);
            chk("ld_bf_vld", bf_vld, 0);
            chk("ld_out_vld", out_vld, 0);
            chk("ld_stage", stage, 0);
            chk("ld_wen0", wr_en_b0, acc & (par(k) == 0));
            chk("ld_wen1", wr_en_b1, acc & par(k));
            chk("ld_sel_din", sel_din, acc);
            if (acc) begin
                chk("ld_wa0", wr_addr_b0, k / 2);
                chk("ld_wa1", wr_addr_b1, k / 2);
                chk("ld_wswap", wr_swap, par(k));
                k++;
                if (k == N) begin ph = 1; c = 0; exp_conj = inv; end
            end
        end else if (ph == 1) begin
            chk("cp_in_rdy", in_rdy, 0);
            chk("cp_busy", busy, 1);
            chk("cp_out_vld", out_vld, 0);
            chk("cp_stage", stage, t_stg[c]);
            chk("cp_bf_vld", bf_vld, t_bf[c]);
            if (t_bf[c] != 0) begin
                chk("cp_rd0", rd_addr_b0, t_rd0[c]);
                chk("cp_rd1", rd_addr_b1, t_rd1[c]);
                chk("cp_rswap", rd_swap, t_rsw[c]);
                chk("cp_tw", tw_addr, t_tw[c]);
            end
            chk("cp_wen0", wr_en_b0, t_wen[c]);
            chk("cp_wen1", wr_en_b1, t_wen[c]);
            if (t_wen[c] != 0) begin
                chk("cp_sel_din", sel_din, 0);
                chk("cp_wa0", wr_addr_b0, t_wa0[c]);
                chk("cp_wa1", wr_addr_b1, t_wa1[c]);
                chk("cp_wswap", wr_swap, t_wsw[c]);
            end
            c++;
            if (c == TOT) begin ph = 2; k = 0; ov = 0; end
        end else begin
            int xfer = ov & out_rdy;
            int ri = brev((k + xfer) % N);
            chk("ul_in_rdy", in_rdy, 0);
            chk("ul_busy", busy, 1);
            chk("ul_out_vld", out_vld, ov);
            chk("ul_stage", stage, 0);
            chk("ul_bf_vld", bf_vld, 0);
            chk("ul_wen", {wr_en_b0, wr_en_b1}, 0);
            chk("ul_rswap", rd_swap, par(ri));
            chk("ul_rd0", rd_addr_b0, ri / 2);
            chk("ul_rd1", rd_addr_b1, ri / 2);
            ov = 1;
            if (xfer != 0) begin
                k++;
                if (k == N) begin ph = 0; k = 0; ov = 0; frames_done++; end
            end
        end
    endtask

    initial begin
        build_tables();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wen", {wr_en_b0, wr_en_b1}, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_bf_vld", bf_vld, 0);
        chk("rst_tw_conj", tw_conj, 0);
        chk("rst_stage", stage, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int cyc = 0; cyc < MAXC && frames_done < 4; cyc++) begin
            in_vld  = ($urandom_range(0, 2) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            inv     = 1'($urandom_range(0, 1));
            if (frames_done == 1 && ph == 1 && c == 20 && !rst_done) begin
                rst = 1'b1; in_vld = 1'b0; rst_done = 1;
            end
            @(negedge clk);
            if (rst) begin
                chk("abort_wen", {wr_en_b0, wr_en_b1}, 0);
                chk("abort_in_rdy", in_rdy, 1);
                chk("abort_busy", busy, 0);
                chk("abort_bf_vld", bf_vld, 0);
                chk("abort_tw_conj", tw_conj, 0);
                ph = 0; k = 0; exp_conj = 0;
                rst = 1'b0;
            end else begin
                check_and_update();
            end
            @(posedge clk); #1;
        end
        chk("frames_done", frames_done, 4);
        chk("rst_exercised", 32'(rst_done), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
